event_trigger_map: RTL and testbench

Maps the received timing-event stream onto the 14 pulse-generator trigger lines of the EVR output stage. Each 8-bit event code indexes a 256-entry × 14-bit mapping RAM, written by software through the register interface. The looked-up bit vector is emitted as single-cycle strobes on `start[13:0]`, which drives the `start` input of the pulse-output settings block directly. The block also provides a software trigger path and a saturating accepted-event counter.

---
 rtl/event_trigger_map.sv | 105 ++++++++++
 tb/tb_event_trigger_map.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_trigger_map.sv
// Event-to-trigger mapping for the EVR output stage: a 2^EVW x NOUT map RAM
// turns each accepted event code into single-cycle strobes on start.
module event_trigger_map #(
  parameter int NOUT = 14,
  parameter int EVW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [EVW-1:0]  event_code,
  input  logic            event_valid,
  input  logic            map_enable,
  input  logic            map_we,
  input  logic [EVW-1:0]  map_addr,
  input  logic [NOUT-1:0] map_wdata,
  output logic [NOUT-1:0] map_rdata,
  input  logic [NOUT-1:0] sw_trig,
  input  logic            cnt_clr,
  output logic [NOUT-1:0] start,
  output logic [31:0]     event_count,
  output logic            busy
);

  localparam int DEPTH = 1 << EVW;

  typedef enum logic {INIT, RUN} state_t;

  state_t          r_state, w_stateNext;
  logic [EVW-1:0]  r_clrAddr, w_clrAddrNext;
  logic [NOUT-1:0] r_map [DEPTH];

  logic            w_accept;
  logic            w_memWe;
  logic [EVW-1:0]  w_memAddr;
  logic [NOUT-1:0] w_memData;

  logic [NOUT-1:0] r_lookup;
  logic [NOUT-1:0] r_swTrigD;
  logic [NOUT-1:0] r_start;
  logic [NOUT-1:0] r_rdata;
  logic [31:0]     r_eventCount;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= INIT;
      r_clrAddr <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_clrAddr <= w_clrAddrNext;
    end
  end

  // While INIT sweeps the RAM it owns the write port, so software writes are dropped.
  always_comb begin
    w_stateNext   = r_state;
    w_clrAddrNext = r_clrAddr;
    w_memWe       = 1'b0;
    w_memAddr     = map_addr;
    w_memData     = map_wdata;
    w_accept      = 1'b0;
    case (r_state)
      INIT: begin
        w_memWe       = reset;
        w_memAddr     = r_clrAddr;
        w_memData     = '0;
        w_clrAddrNext = r_clrAddr + 1'b1;
        if (r_clrAddr == EVW'(DEPTH - 1)) w_stateNext = RUN;
      end
      RUN: begin
        w_memWe  = map_we && reset;
        w_accept = event_valid && map_enable && (event_code != '0);
      end
      default: w_stateNext = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_memWe) r_map[w_memAddr] <= w_memData;
  end

  // Lookups read the RAM in the same edge as a write, so a collision sees old data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lookup     <= '0;
      r_swTrigD    <= '0;
      r_start      <= '0;
      r_rdata      <= '0;
      r_eventCount <= '0;
    end else begin
      r_lookup  <= w_accept ? r_map[event_code] : '0;
      r_swTrigD <= sw_trig;
      r_start   <= r_lookup | r_swTrigD;
      r_rdata   <= r_map[map_addr];
      if (cnt_clr)
        r_eventCount <= '0;
      else if (w_accept && (r_eventCount != '1))
        r_eventCount <= r_eventCount + 32'd1;
    end
  end

  assign start       = r_start;
  assign map_rdata   = r_rdata;
  assign event_count = r_eventCount;
  assign busy        = (r_state == INIT);

endmodule

// File: tb/tb_event_trigger_map.sv
// Scoreboard bench for event_trigger_map: a behavioural model pushes expected
// start values each cycle and they are popped when the DUT's start is sampled.
module tb_event_trigger_map;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  event_code;
  logic        event_valid;
  logic        map_enable;
  logic        map_we;
  logic [7:0]  map_addr;
  logic [13:0] map_wdata;
  logic [13:0] map_rdata;
  logic [13:0] sw_trig;
  logic        cnt_clr;
  logic [13:0] start;
  logic [31:0] event_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [13:0] mMap   [256];
  bit          mKnown [256];
  bit          mRun = 1'b0;
  int          mClr = 0;
  logic [31:0] mCount = '0;
  logic [13:0] sbQ [$];
  logic [13:0] lastStart;
  logic [13:0] obs [5];
  int          busyCycles;

  event_trigger_map #(.NOUT(14), .EVW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .event_code  (event_code),
    .event_valid (event_valid),
    .map_enable  (map_enable),
    .map_we      (map_we),
    .map_addr    (map_addr),
    .map_wdata   (map_wdata),
    .map_rdata   (map_rdata),
    .sw_trig     (sw_trig),
    .cnt_clr     (cnt_clr),
    .start       (start),
    .event_count (event_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus: predict, advance the model, clock the DUT, compare.
  task automatic applyStimulus();
    logic [13:0] expStart;
    logic [13:0] expRd;
    bit          acc;
    bit          rdKnown;
    acc      = reset && mRun && event_valid && (event_code != 8'h00) && map_enable;
    expStart = acc ? mMap[event_code] : 14'h0;
    if (reset) expStart = expStart | sw_trig;
    else begin
      expStart = 14'h0;
      sbQ.delete();
      sbQ.push_back(14'h0);
    end
    sbQ.push_back(expStart);
    expRd   = mMap[map_addr];
    rdKnown = mKnown[map_addr];
    if (!reset) begin
      mRun    = 1'b0;
      mClr    = 0;
      mCount  = '0;
      expRd   = 14'h0;
      rdKnown = 1'b1;
    end else begin
      if (cnt_clr) mCount = '0;
      else if (acc && mCount != 32'hFFFF_FFFF) mCount = mCount + 32'd1;
      if (!mRun) begin
        mMap[mClr]   = 14'h0;
        mKnown[mClr] = 1'b1;
        if (mClr == 255) mRun = 1'b1;
        mClr++;
      end else if (map_we) begin
        mMap[map_addr]   = map_wdata;
        mKnown[map_addr] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("start", {18'h0, start}, {18'h0, sbQ.pop_front()});
    checkOutput("busy", {31'h0, busy}, {31'h0, !mRun});
    checkOutput("event_count", event_count, mCount);
    if (rdKnown) checkOutput("map_rdata", {18'h0, map_rdata}, {18'h0, expRd});
    lastStart = start;
  endtask

  task automatic idleInputs();
    event_valid = 1'b0;
    event_code  = 8'h00;
    map_we      = 1'b0;
    map_addr    = 8'h00;
    map_wdata   = 14'h0;
    sw_trig     = 14'h0;
    cnt_clr     = 1'b0;
  endtask

  task automatic writeMap(input logic [7:0] addr, input logic [13:0] data);
    map_we = 1'b1; map_addr = addr; map_wdata = data;
    applyStimulus();
    map_we = 1'b0;
  endtask

  task automatic sendEvent(input logic [7:0] code);
    event_valid = 1'b1; event_code = code;
    applyStimulus();
    event_valid = 1'b0; event_code = 8'h00;
  endtask

  task automatic waitInitAndReadback(input string tag);
    busyCycles = 0;
    while (busy && busyCycles < 1000) begin
      busyCycles++;
      applyStimulus();
    end
    checkOutput({tag, "_busy_cycles"}, busyCycles, 256);
    map_we = 1'b0;
    for (int a = 0; a < 256; a++) begin
      map_addr = a[7:0];
      applyStimulus();
      checkOutput({tag, "_readback"}, {18'h0, map_rdata}, 32'h0);
    end
    map_addr = 8'h00;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idleInputs();
    map_enable = 1'b1;
    reset      = 1'b0;
    sbQ.push_back(14'h0);

    // Reset and init, with a software write during INIT that must be dropped
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("reset_start", {18'h0, start}, 32'h0);
    checkOutput("reset_count", event_count, 32'h0);
    checkOutput("reset_rdata", {18'h0, map_rdata}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h1);
    reset     = 1'b1;
    map_we    = 1'b1;
    map_addr  = 8'h05;
    map_wdata = 14'h3FFF;
    waitInitAndReadback("init");

    // Basic mapping
    writeMap(8'h2A, 14'h0005);
    sendEvent(8'h2A);
    applyStimulus();
    checkOutput("basic_start", {18'h0, lastStart}, 32'h0005);
    checkOutput("basic_count", event_count, 32'd1);
    applyStimulus();
    checkOutput("basic_one_cycle", {18'h0, lastStart}, 32'h0);

    // Back-to-back events with a null code in the middle
    writeMap(8'h01, 14'h0001);
    writeMap(8'h02, 14'h2000);
    cnt_clr = 1'b1;
    applyStimulus();
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      event_valid = (i < 4);
      case (i)
        0: event_code = 8'h01;
        1: event_code = 8'h02;
        2: event_code = 8'h00;
        3: event_code = 8'h01;
        default: event_code = 8'h00;
      endcase
      applyStimulus();
      obs[i] = lastStart;
    end
    event_valid = 1'b0;
    applyStimulus();
    checkOutput("b2b_0", {18'h0, obs[1]}, 32'h0001);
    checkOutput("b2b_1", {18'h0, obs[2]}, 32'h2000);
    checkOutput("b2b_2", {18'h0, obs[3]}, 32'h0000);
    checkOutput("b2b_3", {18'h0, obs[4]}, 32'h0001);
    checkOutput("b2b_count", event_count, 32'd3);

    // Write/lookup collision, then disable
    writeMap(8'h10, 14'h0003);
    map_we = 1'b1; map_addr = 8'h10; map_wdata = 14'h00FF;
    sendEvent(8'h10);
    map_we = 1'b0;
    applyStimulus();
    checkOutput("collision_old", {18'h0, lastStart}, 32'h0003);
    sendEvent(8'h10);
    applyStimulus();
    checkOutput("collision_new", {18'h0, lastStart}, 32'h00FF);
    map_enable = 1'b0;
    sendEvent(8'h10);
    applyStimulus();
    checkOutput("disabled_start", {18'h0, lastStart}, 32'h0);
    checkOutput("disabled_count", event_count, 32'd5);
    map_enable = 1'b1;

    // Software trigger OR'd with a mapped event
    sw_trig = 14'h0100;
    sendEvent(8'h2A);
    sw_trig = 14'h0;
    applyStimulus();
    checkOutput("sw_or", {18'h0, lastStart}, 32'h0105);
    sw_trig = 14'h0020;
    applyStimulus();
    sw_trig = 14'h0;
    applyStimulus();
    checkOutput("sw_only", {18'h0, lastStart}, 32'h0020);

    // Counter saturation and clear priority
    force dut.r_eventCount = 32'hFFFF_FFFE;
    #1;
    release dut.r_eventCount;
    mCount = 32'hFFFF_FFFE;
    sendEvent(8'h01);
    checkOutput("count_max", event_count, 32'hFFFF_FFFF);
    sendEvent(8'h02);
    checkOutput("count_saturate", event_count, 32'hFFFF_FFFF);
    cnt_clr = 1'b1;
    sendEvent(8'h01);
    cnt_clr = 1'b0;
    checkOutput("count_clr_wins", event_count, 32'h0);
    applyStimulus();
    applyStimulus();

    // Mid-run reset one cycle after an accepted event
    sendEvent(8'h2A);
    reset = 1'b0;
    applyStimulus();
    checkOutput("midreset_start", {18'h0, lastStart}, 32'h0);
    checkOutput("midreset_busy", {31'h0, busy}, 32'h1);
    applyStimulus();
    checkOutput("midreset_start2", {18'h0, lastStart}, 32'h0);
    reset = 1'b1;
    waitInitAndReadback("midreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
